// File: rtl/seg_pkg.sv
// Shared constants and payload types for the 7-segment scan controller.
package seg_pkg;

  localparam int unsigned MAX_DIG = 4;
  localparam logic [7:0]  SEG_BLANK = 8'hFF;

  // Active-low hex glyphs with the decimal point off (bit7 = 1).
  localparam logic [7:0] HEX7 [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic [3:0]  dp;
    logic [15:0] digits;
  } seg_data_t;

endpackage

// File: rtl/seg_scan_if.sv
// Display data in, scan position and segment code out.
interface seg_scan_if;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        din_vld;
  logic        blank_lz;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (
    output din, dp_in, din_vld, blank_lz,
    input  sel, seg, frame_done
  );

  modport slave (
    input  din, dp_in, din_vld, blank_lz,
    output sel, seg, frame_done
  );
endinterface

// File: rtl/seg_hex_dec.sv
// Nibble to active-low 7-segment glyph (g..a), decimal point excluded.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = HEX7[nib][6:0];
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scan controller with frame-aligned double buffering
// and optional leading-zero blanking.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIG_NUM  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [1:0]       IDX_MAX = 2'(DIG_NUM - 1);

  logic [CNT_W-1:0]   cnt;
  logic [1:0]         idx;
  seg_data_t          active_q;
  seg_data_t          pending_q;
  logic               pend_q;
  logic               tick_c;
  logic               wrap_tick_c;
  logic               zero_run;
  logic [MAX_DIG-1:0] blank_c;
  logic [3:0]         nib_c;
  logic [6:0]         hex_c;
  logic [7:0]         code_c;

  always_comb begin
    tick_c      = (cnt == CNT_MAX);
    wrap_tick_c = tick_c && (idx == IDX_MAX);
  end

  // Slot divider and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick_c) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? 2'd0 : idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // New data waits in pending until the frame boundary; a load landing on
  // the boundary itself goes straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
    end else if (wrap_tick_c) begin
      pend_q <= 1'b0;
      if (bus.din_vld) begin
        active_q <= '{dp: bus.dp_in, digits: bus.din};
      end else if (pend_q) begin
        active_q <= pending_q;
      end
    end else if (bus.din_vld) begin
      pending_q <= '{dp: bus.dp_in, digits: bus.din};
      pend_q    <= 1'b1;
    end
  end

  // A digit is blank when it and every digit above it are zero.
  always_comb begin
    blank_c  = '0;
    zero_run = 1'b1;
    for (int k = int'(MAX_DIG) - 1; k >= 1; k--) begin
      if (k < int'(DIG_NUM)) begin
        zero_run   = zero_run & (active_q.digits[4*k +: 4] == 4'h0);
        blank_c[k] = bus.blank_lz & zero_run;
      end
    end
  end

  always_comb begin
    nib_c  = active_q.digits[{idx, 2'b00} +: 4];
    code_c = blank_c[idx] ? SEG_BLANK : {~active_q.dp[idx], hex_c};
  end

  seg_hex_dec u_hex_dec (
    .nib   (nib_c),
    .seg_c (hex_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sel        <= 4'd0;
      bus.seg        <= SEG_BLANK;
      bus.frame_done <= 1'b0;
    end else begin
      bus.sel        <= {2'b00, idx};
      bus.seg        <= code_c;
      bus.frame_done <= wrap_tick_c;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: a frame-level reference model checked
// every cycle, plus directed scenarios with hand-computed glyphs.
module tb_seg_scan;

  localparam int SD = 4;
  localparam int DN = 4;
  localparam int FRAME = SD * DN;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  seg_scan_if bus ();

  seg_scan #(.SCAN_DIV(SD), .DIG_NUM(DN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] hx [16];
  initial begin
    hx = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mcode(input logic [15:0] v, input logic [3:0] dp,
                                       input int k, input logic blz);
    logic [15:0] upper;
    logic [3:0]  nb;
    logic [7:0]  h;
    upper = v >> (4 * k);
    nb    = 4'(upper & 16'hF);
    h     = hx[nb];
    if (k > 0 && blz && upper == 16'h0) return 8'hFF;
    return dp[k] ? (h & 8'h7F) : h;
  endfunction

  // Reference: edges since reset give the slot; the shown data is the most
  // recent load captured at or before the last frame boundary.
  int          n;
  logic [15:0] act_v, lat_v;
  logic [3:0]  act_d, lat_d;
  initial begin
    logic [3:0] es;
    logic [7:0] eg;
    logic       ef;
    n = 0; act_v = '0; act_d = '0; lat_v = '0; lat_d = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        n = 0; act_v = '0; act_d = '0; lat_v = '0; lat_d = '0;
        es = 4'd0; eg = 8'hFF; ef = 1'b0;
      end else begin
        es = 4'((n / SD) % DN);
        eg = mcode(act_v, act_d, int'(es), bus.blank_lz);
        ef = ((n % FRAME) == FRAME - 1);
        if (bus.din_vld) begin
          lat_v = bus.din;
          lat_d = bus.dp_in;
        end
        if ((n % FRAME) == FRAME - 1) begin
          act_v = lat_v;
          act_d = lat_d;
        end
        n++;
      end
      #1;
      chk("model_sel", 32'(bus.sel), 32'(es));
      chk("model_seg", 32'(bus.seg), 32'(eg));
      chk("model_frame_done", 32'(bus.frame_done), 32'(ef));
    end
  end

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    @(negedge clk);
    bus.din = v; bus.dp_in = dp; bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_done === 1'b1) return;
    end
    chk("wait_frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < DN; k++) begin
      repeat ((k == 0) ? 1 : SD) @(posedge clk);
      #1;
      chk({tag, "_sel"}, 32'(bus.sel), 32'(k));
      chk({tag, "_seg"}, 32'(bus.seg), 32'(e[k]));
    end
  endtask

  initial begin
    int fd_cnt;
    int dbl;
    logic prev_fd;
    rst_n = 1'b0;
    bus.din = '0; bus.dp_in = '0; bus.din_vld = 1'b0; bus.blank_lz = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_seg", 32'(bus.seg), 32'hFF);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_seg", 32'(bus.seg), 32'hC0);
    chk("first_sel", 32'(bus.sel), 32'd0);

    // Load while digit 1 is being scanned; shows from the next frame.
    repeat (5) @(negedge clk);
    bus.din = 16'h1234; bus.dp_in = 4'h0; bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    wait_frame();
    check_frame("load1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Frame pacing.
    fd_cnt = 0; dbl = 0; prev_fd = 1'b0;
    repeat (64) begin
      @(posedge clk);
      #1;
      if (bus.frame_done === 1'b1) begin
        fd_cnt++;
        if (prev_fd) dbl++;
      end
      prev_fd = bus.frame_done;
    end
    chk("fd_count_64", 32'(fd_cnt), 32'd4);
    chk("fd_back_to_back", 32'(dbl), 32'd0);

    // Leading-zero blanking.
    bus.blank_lz = 1'b1;
    load(16'h0050, 4'h0);
    wait_frame();
    check_frame("blank0050", 8'hC0, 8'h92, 8'hFF, 8'hFF);
    load(16'h0000, 4'h0);
    wait_frame();
    check_frame("blank0000", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // Decimal point.
    bus.blank_lz = 1'b0;
    load(16'h0008, 4'b0010);
    wait_frame();
    check_frame("dp0008", 8'h80, 8'h40, 8'hC0, 8'hC0);

    // Random traffic against the model.
    repeat (320) begin
      @(negedge clk);
      bus.din_vld = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: bus.din = 16'($urandom);
        1: bus.din = 16'($urandom) & 16'h00FF;
        2: bus.din = 16'($urandom) & 16'h000F;
        default: bus.din = 16'h0;
      endcase
      bus.dp_in = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
    end
    @(negedge clk);
    bus.din_vld = 1'b0; bus.blank_lz = 1'b0; bus.dp_in = 4'h0;

    // Load coincident with the frame boundary bypasses pending.
    wait_frame();
    repeat (FRAME) @(negedge clk);
    bus.din = 16'hABCD; bus.dp_in = 4'h0; bus.din_vld = 1'b1;
    @(posedge clk);
    #1;
    bus.din_vld = 1'b0;
    chk("coinc_frame_done", 32'(bus.frame_done), 32'd1);
    check_frame("coincABCD", 8'hA1, 8'hC6, 8'h83, 8'h88);

    // Asynchronous reset while digit 2 is scanned.
    wait_frame();
    repeat (2 * SD + 1) @(posedge clk);
    #1;
    chk("pre_rst_sel", 32'(bus.sel), 32'd2);
    bus.din = 16'h5555;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 32'(bus.sel), 32'd0);
    chk("async_rst_seg", 32'(bus.seg), 32'hFF);
    chk("async_rst_fd", 32'(bus.frame_done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame();
    check_frame("post_rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
